control_temporizador: RTL and testbench
=======================================

CONTROL_TEMPORIZADOR -- requirements
Module: control_temporizador

Interface
REQ-001 Parameter N, default 8: count width in bits.
REQ-002 Parameter TICK_DIV, default 4: clock cycles per decrement, legal range >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  level sampled each cycle; captures init_number.
REQ-006 init_number  input  N  countdown start value.
REQ-007 start  input  1  begin counting, or resume counting from PAUSED.
REQ-008 pause  input  1  freeze counting while in RUN.
REQ-009 abort  input  1  cancel the countdown and return to IDLE.
REQ-010 count  output  N  current countdown value (registered).
REQ-011 state  output  3  encoded FSM state (package enum).
REQ-012 busy  output  1  high in RUN or PAUSED.
REQ-013 done  output  1  one-cycle pulse; high in the first cycle of DONE only.
REQ-014 expired  output  1  high for every cycle in DONE.

Function
REQ-015 FSM states SHALL be IDLE, LOADED, RUN, PAUSED and DONE.
REQ-016 Command priority in every state SHALL be abort > load > pause > start; any command illegal in the current state is ignored.
REQ-017 IDLE SHALL hold count=0.
  - load with init_number!=0 -> LOADED, count<=init_number.
  - load with init_number==0 -> DONE, count=0.
REQ-018 LOADED SHALL respond to commands as follows.
  - load: reload count and stay in LOADED.
  - start: -> RUN with prescaler<=0.
  - abort: -> IDLE, count<=0.
REQ-019 RUN: prescaler SHALL increment each cycle; when prescaler==TICK_DIV-1, a tick occurs, prescaler<=0 and count<=count-1.
REQ-020 RUN with a tick at count==1 SHALL set count<=0 and move to DONE on the same edge, so done and expired rise together with count==0.
REQ-021 RUN with pause -> PAUSED; the prescaler and count are held, and a tick in the same cycle SHALL NOT decrement.
REQ-022 RUN SHALL ignore load and start; RUN with abort -> IDLE, count<=0.
REQ-023 PAUSED SHALL respond to commands as follows.
  - start: -> RUN, prescaler resumes from its held value.
  - abort: -> IDLE.
  - load and pause: ignored.
REQ-024 DONE SHALL hold count=0.
  - load: same rules as IDLE.
  - abort: -> IDLE.
  - start and pause: ignored.
REQ-025 count SHALL never wrap below 0; a decrement is only issued when count>0.
REQ-026 When TICK_DIV=1, the prescaler SHALL be absent and a tick SHALL occur every RUN cycle.
REQ-027 Prescaler width SHALL be max(1,$clog2(TICK_DIV)) bits.

Reset
REQ-028 rst=1 at a clock edge SHALL force the following values, overriding all commands in that cycle and from any state including mid-count.
  - state=IDLE, count=0, prescaler=0.
  - busy=0, done=0, expired=0.
REQ-029 The first clock edge with rst=0 SHALL evaluate commands normally.

Structure
REQ-030 Package control_temporizador_pkg SHALL hold the state enum typedef (3-bit) and the state encodings.
REQ-031 The decrement SHALL be a sub-module named decrementador (N-bit ripple-borrow subtract-by-one, combinational); the FSM, prescaler and count register live in control_temporizador.
REQ-032 All outputs SHALL be registered or decoded solely from registered state.

Verification (N=8, TICK_DIV=4)
REQ-033 Reset: hold rst for 2 cycles -> state=IDLE, count=0, busy=0, done=0, expired=0.
REQ-034 Full count: load 5, then start at edge k.
  - count reads 4,3,2,1,0 at edges k+4, k+8, k+12, k+16, k+20.
  - done=1 only in the cycle after edge k+20; expired stays 1 afterwards.
REQ-035 Pause/resume: load 3, start, pause at 2 cycles into RUN, hold 10 cycles, then start.
  - count stays 3 during the pause.
  - reaches 0 exactly 12 RUN cycles after the first start, not counting paused cycles.
REQ-036 Collisions: abort+load+start in the same cycle in RUN -> IDLE, count=0; load in RUN with count=7 -> ignored, count unchanged.
REQ-037 Zero load: load 0 from IDLE -> DONE next cycle, done single pulse, count=0; a following start -> no change.
REQ-038 Reset mid-run: rst=1 at count=2 -> IDLE, count=0, busy=0, no done pulse.

Source files
------------

// File: rtl/control_temporizador_pkg.sv
// Shared types for the countdown timer: FSM state encoding and prescaler ops.
package control_temporizador_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PS_HOLD = 2'd0,
    PS_CLR  = 2'd1,
    PS_INC  = 2'd2
  } presc_op_t;

  function automatic int presc_w(input int tick_div);
    return (tick_div <= 2) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/control_temporizador_decrementador.sv
// N-bit ripple-borrow subtract-by-one, purely combinational.
module decrementador #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);
  logic [N:0] borrow;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign y[i]          = a[i] ^ borrow[i];
    assign borrow[i + 1] = borrow[i] & ~a[i];
  end

endmodule

// File: rtl/control_temporizador.sv
// Countdown timer: load/start/pause/abort FSM with a prescaled decrement.
module control_temporizador
  import control_temporizador_pkg::*;
#(
  parameter int N        = 8,
  parameter int TICK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] init_number,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] count,
  output state_t       state,
  output logic         busy,
  output logic         done,
  output logic         expired
);
  localparam int PW = presc_w(TICK_DIV);

  state_t      state_nxt;
  logic [N-1:0] count_nxt, count_dec;
  presc_op_t   presc_op;
  logic        tick;
  logic        done_q;

  decrementador #(.N(N)) u_dec (.a(count), .y(count_dec));

  // With TICK_DIV==1 every RUN cycle is a tick and no prescaler exists.
  if (TICK_DIV == 1) begin : g_no_presc
    assign tick = 1'b1;
  end else begin : g_presc
    logic [PW-1:0] presc;
    always_ff @(posedge clk) begin
      if (rst) presc <= '0;
      else if (presc_op == PS_CLR) presc <= '0;
      else if (presc_op == PS_INC) presc <= presc + 1'b1;
    end
    assign tick = (presc == PW'(TICK_DIV - 1));
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    presc_op  = PS_HOLD;
    case (state)
      IDLE, DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (load) begin
          state_nxt = (init_number != '0) ? LOADED : DONE;
          count_nxt = init_number;
        end
      end
      LOADED: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (load) begin
          count_nxt = init_number;
        end else if (start) begin
          state_nxt = RUN;
          presc_op  = PS_CLR;
        end
      end
      RUN: begin
        // load and start have no effect here; pause wins over a same-cycle tick
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
          presc_op  = PS_CLR;
        end else if (pause) begin
          state_nxt = PAUSED;
        end else if (tick) begin
          presc_op = PS_CLR;
          if (count <= N'(1)) begin
            state_nxt = DONE;
            count_nxt = '0;
          end else begin
            count_nxt = count_dec;
          end
        end else begin
          presc_op = PS_INC;
        end
      end
      PAUSED: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
          presc_op  = PS_CLR;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        presc_op  = PS_CLR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      done_q <= (state_nxt == DONE) && (state != DONE);
    end
  end

  assign busy    = (state == RUN) || (state == PAUSED);
  assign done    = done_q;
  assign expired = (state == DONE);

endmodule

// File: tb/tb_control_temporizador.sv
// Directed scoreboard bench for control_temporizador (N=8, TICK_DIV=4).
module tb_control_temporizador;
  import control_temporizador_pkg::*;

  logic       clk = 1'b0;
  logic       rst, load, start, pause, abort;
  logic [7:0] init_number;
  logic [7:0] count;
  state_t     state;
  logic       busy, done, expired;

  control_temporizador #(.N(8), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .init_number(init_number),
    .start(start), .pause(pause), .abort(abort),
    .count(count), .state(state), .busy(busy), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    state_t     st;
    logic [7:0] cnt;
    logic       bsy;
    logic       dn;
    logic       ex;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compares every expectation due after the most recent edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      total++;
      if (e.cyc < cyc_cnt) begin
        bad++;
        $display("FAIL %s: missed check for cycle %0d (now %0d)", e.tag, e.cyc, cyc_cnt);
      end else if (state !== e.st || count !== e.cnt || busy !== e.bsy ||
                   done !== e.dn || expired !== e.ex) begin
        bad++;
        $display("FAIL %s cyc=%0d: got st=%0d cnt=%0d busy=%b done=%b exp=%b, want st=%0d cnt=%0d busy=%b done=%b exp=%b",
                 e.tag, e.cyc, state, count, busy, done, expired,
                 e.st, e.cnt, e.bsy, e.dn, e.ex);
      end
    end
  end

  task automatic expect_at(input int c, input string tag, input state_t st,
                           input int cnt, input logic bsy, input logic dn, input logic ex);
    exp_t x;
    x.cyc = c; x.tag = tag; x.st = st; x.cnt = 8'(cnt);
    x.bsy = bsy; x.dn = dn; x.ex = ex;
    q.push_back(x);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    rst = 0; load = 0; start = 0; pause = 0; abort = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    idle_in();
    init_number = '0;
    rst = 1;
    start = 1; load = 1; init_number = 8'd9;
    expect_at(1, "reset1", IDLE, 0, 0, 0, 0);
    expect_at(2, "reset2", IDLE, 0, 0, 0, 0);
    tick(2);
    idle_in();

    // Full count: load 5, start at edge k
    load = 1; init_number = 8'd5;
    expect_at(cyc_cnt + 1, "load5", LOADED, 5, 0, 0, 0);
    tick();
    load = 0; start = 1;
    expect_at(cyc_cnt + 1, "start5", RUN, 5, 1, 0, 0);
    tick();
    start = 0;
    k = cyc_cnt;
    for (int j = 1; j <= 20; j++) begin
      if (j == 20) expect_at(k + j, "full_end", DONE, 0, 0, 1, 1);
      else         expect_at(k + j, "full_run", RUN, 5 - j / 4, 1, 0, 0);
    end
    expect_at(k + 21, "full_exp1", DONE, 0, 0, 0, 1);
    expect_at(k + 22, "full_exp2", DONE, 0, 0, 0, 1);
    tick(22);
    abort = 1;
    expect_at(cyc_cnt + 1, "abort_done", IDLE, 0, 0, 0, 0);
    tick();
    abort = 0;

    // Pause/resume: load 3, start, pause after 2 RUN cycles, hold 10, restart
    load = 1; init_number = 8'd3;
    expect_at(cyc_cnt + 1, "load3", LOADED, 3, 0, 0, 0);
    tick();
    load = 0; start = 1;
    expect_at(cyc_cnt + 1, "start3", RUN, 3, 1, 0, 0);
    tick();
    start = 0;
    k = cyc_cnt;
    expect_at(k + 1, "pr_run", RUN, 3, 1, 0, 0);
    expect_at(k + 2, "pr_run", RUN, 3, 1, 0, 0);
    for (int j = 3; j <= 12; j++) expect_at(k + j, "pr_paused", PAUSED, 3, 1, 0, 0);
    expect_at(k + 13, "pr_resume", RUN, 3, 1, 0, 0);
    expect_at(k + 14, "pr_run", RUN, 3, 1, 0, 0);
    for (int j = 15; j <= 18; j++) expect_at(k + j, "pr_run", RUN, 2, 1, 0, 0);
    for (int j = 19; j <= 22; j++) expect_at(k + j, "pr_run", RUN, 1, 1, 0, 0);
    expect_at(k + 23, "pr_end", DONE, 0, 0, 1, 1);
    expect_at(k + 24, "pr_exp", DONE, 0, 0, 0, 1);
    tick(2);
    pause = 1;
    tick();
    pause = 0;
    tick(9);
    start = 1;
    tick();
    start = 0;
    tick(11);
    // Start in DONE is ignored
    start = 1; pause = 1;
    expect_at(cyc_cnt + 1, "done_start", DONE, 0, 0, 0, 1);
    tick();
    start = 0; pause = 0; abort = 1;
    expect_at(cyc_cnt + 1, "abort2", IDLE, 0, 0, 0, 0);
    tick();
    abort = 0;

    // Collisions in RUN
    load = 1; init_number = 8'd7;
    expect_at(cyc_cnt + 1, "load7", LOADED, 7, 0, 0, 0);
    tick();
    load = 0; start = 1;
    expect_at(cyc_cnt + 1, "start7", RUN, 7, 1, 0, 0);
    tick();
    start = 0; load = 1; init_number = 8'd3;
    expect_at(cyc_cnt + 1, "run_load_ign", RUN, 7, 1, 0, 0);
    tick();
    abort = 1; load = 1; start = 1;
    expect_at(cyc_cnt + 1, "run_collide", IDLE, 0, 0, 0, 0);
    tick();
    idle_in();

    // Zero load
    load = 1; init_number = 8'd0;
    expect_at(cyc_cnt + 1, "zero_load", DONE, 0, 0, 1, 1);
    tick();
    load = 0; start = 1;
    expect_at(cyc_cnt + 1, "zero_start", DONE, 0, 0, 0, 1);
    tick();
    start = 0;
    expect_at(cyc_cnt + 1, "zero_hold", DONE, 0, 0, 0, 1);
    tick();
    abort = 1;
    expect_at(cyc_cnt + 1, "abort3", IDLE, 0, 0, 0, 0);
    tick();
    abort = 0;

    // Reset mid-run at count 2
    load = 1; init_number = 8'd3;
    expect_at(cyc_cnt + 1, "load3b", LOADED, 3, 0, 0, 0);
    tick();
    load = 0; start = 1;
    tick();
    start = 0;
    k = cyc_cnt;
    for (int j = 1; j <= 3; j++) expect_at(k + j, "mr_run", RUN, 3, 1, 0, 0);
    expect_at(k + 4, "mr_run", RUN, 2, 1, 0, 0);
    expect_at(k + 5, "mr_run", RUN, 2, 1, 0, 0);
    for (int j = 6; j <= 9; j++) expect_at(k + j, "mr_reset", IDLE, 0, 0, 0, 0);
    tick(5);
    rst = 1; start = 1;
    tick();
    rst = 0; start = 0;
    tick(5);

    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expectations never checked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
